// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request, response and RAM-port signals of the memory controller
interface mem_ctrl_if;
    logic        rdy;
    logic        rollback;
    logic        if_en;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_en;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_w_data;
    logic        lsb_done;
    logic [31:0] lsb_r_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  rdy, rollback, if_en, if_addr, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
               mem_din, io_buffer_full,
        output if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, rollback, if_en, if_addr, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
               mem_din, io_buffer_full,
        input  if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store requests onto a byte-wide RAM port
module mem_ctrl (
    input logic        clk,
    input logic        rst,
    mem_ctrl_if.slave  b
);
    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t      state, state_n;
    logic [2:0]  stage, stage_n, len, len_n, stage_p1;
    logic [31:0] addr, addr_n, w_data, w_data_n;
    logic        prime, prime_n, last_lsb, last_lsb_n;
    logic        if_done_n, lsb_done_n, mem_wr_n;
    logic [31:0] if_data_n, lsb_r_data_n, mem_a_n;
    logic [7:0]  mem_dout_n;
    logic        grant_lsb, accept, stall, last;
    logic [3:0]  nxt;

    assign grant_lsb = b.lsb_en && !(b.if_en && last_lsb);
    assign accept    = (b.if_en || b.lsb_en) && !b.rollback && !b.if_done && !b.lsb_done;
    assign stall     = b.io_buffer_full && addr[17:16] == 2'b11;
    assign nxt       = prime ? 4'd1 : {1'b0, stage} + 4'd2;
    assign stage_p1  = stage + 3'd1;
    assign last      = stage == len - 3'd1;

    // next-state and next-output logic; prime marks the first read cycle with no byte back yet
    always_comb begin
        state_n      = state;
        stage_n      = stage;
        len_n        = len;
        addr_n       = addr;
        w_data_n     = w_data;
        prime_n      = prime;
        last_lsb_n   = last_lsb;
        if_done_n    = 1'b0;
        lsb_done_n   = 1'b0;
        if_data_n    = b.if_data;
        lsb_r_data_n = b.lsb_r_data;
        mem_a_n      = b.mem_a;
        mem_dout_n   = b.mem_dout;
        mem_wr_n     = 1'b0;
        case (state)
            IDLE: if (accept) begin
                last_lsb_n   = grant_lsb;
                prime_n      = 1'b1;
                stage_n      = 3'd0;
                addr_n       = grant_lsb ? b.lsb_addr : b.if_addr;
                len_n        = grant_lsb ? b.lsb_len : 3'd4;
                w_data_n     = b.lsb_w_data;
                mem_a_n      = addr_n;
                mem_dout_n   = b.lsb_w_data[7:0];
                state_n      = !grant_lsb ? IF_RD : (b.lsb_wr ? LS_WR : LS_RD);
                mem_wr_n     = grant_lsb && b.lsb_wr && !(b.io_buffer_full && b.lsb_addr[17:16] == 2'b11);
                lsb_r_data_n = (grant_lsb && !b.lsb_wr) ? 32'd0 : b.lsb_r_data;
            end
            IF_RD, LS_RD: if (b.rollback) begin
                state_n = IDLE;
                stage_n = 3'd0;
                prime_n = 1'b0;
                mem_a_n = 32'd0;
            end else begin
                prime_n = 1'b0;
                if (nxt < {1'b0, len}) mem_a_n = addr + {28'd0, nxt};
                if (!prime) begin
                    if (state == IF_RD) if_data_n[{stage[1:0], 3'b000} +: 8] = b.mem_din;
                    else lsb_r_data_n[{stage[1:0], 3'b000} +: 8] = b.mem_din;
                    if (last) begin
                        state_n    = IDLE;
                        stage_n    = 3'd0;
                        mem_a_n    = 32'd0;
                        if_done_n  = state == IF_RD;
                        lsb_done_n = state == LS_RD;
                    end else stage_n = stage_p1;
                end
            end
            LS_WR: if (b.mem_wr && last) begin
                state_n    = IDLE;
                stage_n    = 3'd0;
                mem_a_n    = 32'd0;
                lsb_done_n = 1'b1;
            end else begin
                mem_wr_n = !stall;
                if (b.mem_wr) begin
                    stage_n    = stage_p1;
                    mem_a_n    = addr + {29'd0, stage_p1};
                    mem_dout_n = w_data[{stage_p1[1:0], 3'b000} +: 8];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // register everything; rdy low freezes the whole controller
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            stage        <= 3'd0;
            len          <= 3'd0;
            addr         <= 32'd0;
            w_data       <= 32'd0;
            prime        <= 1'b0;
            last_lsb     <= 1'b0;
            b.if_done    <= 1'b0;
            b.lsb_done   <= 1'b0;
            b.if_data    <= 32'd0;
            b.lsb_r_data <= 32'd0;
            b.mem_a      <= 32'd0;
            b.mem_dout   <= 8'd0;
            b.mem_wr     <= 1'b0;
        end else if (b.rdy) begin
            state        <= state_n;
            stage        <= stage_n;
            len          <= len_n;
            addr         <= addr_n;
            w_data       <= w_data_n;
            prime        <= prime_n;
            last_lsb     <= last_lsb_n;
            b.if_done    <= if_done_n;
            b.lsb_done   <= lsb_done_n;
            b.if_data    <= if_data_n;
            b.lsb_r_data <= lsb_r_data_n;
            b.mem_a      <= mem_a_n;
            b.mem_dout   <= mem_dout_n;
            b.mem_wr     <= mem_wr_n;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of arbitration, read/write sequencing, I/O stall, rollback, rdy and reset
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  ram [0:4095];
    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    int          n;
    int          base;
    bit          saw;
    logic [31:0] exp_w;

    mem_ctrl_if b();
    mem_ctrl dut (.clk(clk), .rst(rst), .b(b));

    always #5 clk = ~clk;

    // RAM model: byte returned the cycle after its address, frozen with the controller when rdy is low
    always @(posedge clk) begin
        if (b.rdy) begin
            b.mem_din <= ram[b.mem_a[11:0]];
            if (b.mem_wr) begin
                wa.push_back(b.mem_a);
                wd.push_back(b.mem_dout);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit lsb, input int lim, output int cnt, output bit wr);
        cnt = 0;
        wr = 1'b0;
        do begin
            @(negedge clk);
            cnt++;
            wr |= b.mem_wr;
        end while (!(lsb ? b.lsb_done : b.if_done) && cnt < lim);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
        ram[12'h104] = 8'h93; ram[12'h105] = 8'h05; ram[12'h106] = 8'h10;
        ram[12'h200] = 8'h34; ram[12'h201] = 8'h12;
        b.rdy = 1'b1; b.rollback = 1'b0; b.io_buffer_full = 1'b0;
        b.if_en = 1'b0; b.if_addr = 32'd0;
        b.lsb_en = 1'b0; b.lsb_wr = 1'b0; b.lsb_addr = 32'd0; b.lsb_len = 3'd0; b.lsb_w_data = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_if_done", b.if_done, 0);
        chk("rst_lsb_done", b.lsb_done, 0);
        chk("rst_mem_wr", b.mem_wr, 0);
        chk("rst_mem_a", b.mem_a, 0);
        chk("rst_mem_dout", b.mem_dout, 0);
        chk("rst_if_data", b.if_data, 0);
        chk("rst_lsb_r_data", b.lsb_r_data, 0);
        rst = 1'b0;

        b.if_en = 1'b1; b.if_addr = 32'h100;
        wait_done(1'b0, 20, n, saw);
        chk("fetch_latency", n, 6);
        chk("fetch_data", b.if_data, 32'h00000513);
        chk("fetch_no_write", saw, 0);
        b.if_en = 1'b0;
        @(negedge clk);

        b.if_en = 1'b1; b.if_addr = 32'h100;
        b.lsb_en = 1'b1; b.lsb_wr = 1'b0; b.lsb_addr = 32'h200; b.lsb_len = 3'd2;
        wait_done(1'b1, 20, n, saw);
        chk("tie1_lsb_latency", n, 4);
        chk("tie1_lsb_data", b.lsb_r_data, 32'h00001234);
        chk("tie1_if_idle", b.if_done, 0);
        b.lsb_en = 1'b0;
        wait_done(1'b0, 20, n, saw);
        chk("tie1_fetch_latency", n, 7);
        chk("tie1_fetch_data", b.if_data, 32'h00000513);
        b.if_en = 1'b0;
        @(negedge clk);

        b.lsb_en = 1'b1; b.lsb_addr = 32'h201; b.lsb_len = 3'd1;
        wait_done(1'b1, 20, n, saw);
        chk("load1_latency", n, 3);
        chk("load1_data", b.lsb_r_data, 32'h00000012);
        b.lsb_en = 1'b0;
        @(negedge clk);

        b.if_en = 1'b1; b.if_addr = 32'h100;
        b.lsb_en = 1'b1; b.lsb_addr = 32'h200; b.lsb_len = 3'd1;
        wait_done(1'b0, 20, n, saw);
        chk("tie2_fetch_latency", n, 6);
        chk("tie2_fetch_data", b.if_data, 32'h00000513);
        chk("tie2_lsb_idle", b.lsb_done, 0);
        b.if_en = 1'b0;
        wait_done(1'b1, 20, n, saw);
        chk("tie2_lsb_latency", n, 4);
        chk("tie2_lsb_data", b.lsb_r_data, 32'h00000034);
        b.lsb_en = 1'b0;
        @(negedge clk);

        base = wa.size();
        b.lsb_en = 1'b1; b.lsb_wr = 1'b1; b.lsb_addr = 32'h30000; b.lsb_len = 3'd1; b.lsb_w_data = 32'h41;
        b.io_buffer_full = 1'b1;
        @(negedge clk);
        chk("io_stall_c1", b.mem_wr, 0);
        @(negedge clk);
        chk("io_stall_c2", b.mem_wr, 0);
        @(negedge clk);
        b.io_buffer_full = 1'b0;
        chk("io_stall_c3", b.mem_wr, 0);
        @(negedge clk);
        chk("io_write_c4", b.mem_wr, 1);
        chk("io_write_addr", b.mem_a, 32'h30000);
        chk("io_write_byte", b.mem_dout, 32'h41);
        @(negedge clk);
        chk("io_done_c5", b.lsb_done, 1);
        chk("io_write_count", wa.size() - base, 1);
        chk("io_logged_byte", wd.size() > base ? wd[base] : 8'hxx, 32'h41);
        b.lsb_en = 1'b0; b.lsb_wr = 1'b0;
        @(negedge clk);

        b.lsb_en = 1'b1; b.lsb_addr = 32'h100; b.lsb_len = 3'd4;
        repeat (4) @(negedge clk);
        b.rollback = 1'b1; b.lsb_en = 1'b0;
        @(negedge clk);
        b.rollback = 1'b0;
        chk("rb_rd_no_done", b.lsb_done, 0);
        chk("rb_rd_mem_a", b.mem_a, 0);
        chk("rb_rd_idle", 32'(dut.state), 0);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw |= b.lsb_done;
        end
        chk("rb_rd_never_done", saw, 0);
        b.if_en = 1'b1; b.if_addr = 32'h100;
        wait_done(1'b0, 20, n, saw);
        chk("rb_fetch_latency", n, 6);
        chk("rb_fetch_data", b.if_data, 32'h00000513);
        b.if_en = 1'b0;
        @(negedge clk);

        b.lsb_en = 1'b1; b.lsb_addr = 32'h200; b.lsb_len = 3'd1;
        repeat (2) @(negedge clk);
        b.rollback = 1'b1; b.lsb_en = 1'b0;
        @(negedge clk);
        b.rollback = 1'b0;
        chk("rb_last_no_done", b.lsb_done, 0);
        chk("rb_last_mem_a", b.mem_a, 0);
        @(negedge clk);

        base = wa.size();
        exp_w = 32'hDEADBEEF;
        b.lsb_en = 1'b1; b.lsb_wr = 1'b1; b.lsb_addr = 32'h300; b.lsb_len = 3'd4; b.lsb_w_data = exp_w;
        repeat (2) @(negedge clk);
        b.rollback = 1'b1;
        @(negedge clk);
        b.rollback = 1'b0;
        wait_done(1'b1, 10, n, saw);
        chk("rb_wr_done_latency", n, 2);
        b.lsb_en = 1'b0; b.lsb_wr = 1'b0;
        chk("rb_wr_count", wa.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            chk("rb_wr_addr", wa.size() > base + k ? wa[base + k] : 32'hx, 32'h300 + k);
            chk("rb_wr_byte", wd.size() > base + k ? wd[base + k] : 8'hxx, {24'd0, exp_w[8 * k +: 8]});
        end
        @(negedge clk);

        b.if_en = 1'b1; b.if_addr = 32'h104;
        repeat (3) @(negedge clk);
        b.rdy = 1'b0;
        repeat (2) @(negedge clk);
        b.rdy = 1'b1;
        wait_done(1'b0, 20, n, saw);
        chk("rdy_fetch_latency", n, 3);
        chk("rdy_fetch_data", b.if_data, 32'h00100593);
        b.if_en = 1'b0;
        @(negedge clk);

        b.lsb_en = 1'b1; b.lsb_wr = 1'b1; b.lsb_addr = 32'h400; b.lsb_len = 3'd4; b.lsb_w_data = 32'h11223344;
        repeat (2) @(negedge clk);
        chk("st_mid_wr", b.mem_wr, 1);
        chk("st_mid_byte", b.mem_dout, 32'h33);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_wr", b.mem_wr, 0);
        chk("rst_mid_mem_a", b.mem_a, 0);
        chk("rst_mid_mem_dout", b.mem_dout, 0);
        chk("rst_mid_lsb_done", b.lsb_done, 0);
        chk("rst_mid_if_data", b.if_data, 0);
        chk("rst_mid_lsb_r_data", b.lsb_r_data, 0);
        chk("rst_mid_state", 32'(dut.state), 0);
        rst = 1'b0; b.lsb_en = 1'b0; b.lsb_wr = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
